// File: rtl/arbiter4_if.sv
// Handshake bundle between four producers, the arbiter and one consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface arbiter4_if #(
  parameter int DW = 8
);
  logic [3:0]      valid_in;
  logic [4*DW-1:0] data_in;
  logic            ready_in;
  logic [3:0]      ready_out;
  logic            valid_out;
  logic [DW-1:0]   data_out;

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out
  );

  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out
  );
endinterface

// File: rtl/arbiter4.sv
// Four-way round-robin arbiter merging four valid/ready streams into one
// registered output beat per cycle. A full, stalled output register blocks
// every input.
module arbiter4 #(
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  arbiter4_if.slave   bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][DW-1:0] lane_data;
  logic [NUM_LANES-1:0]         grant;
  logic [1:0]                   gidx;
  logic                         can_accept;
  logic                         xfer;

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic [1:0]    ptr_q,   ptr_d;

  // First requester at or after ptr, scanning upward with wrap.
  function automatic logic [NUM_LANES-1:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                                   input logic [1:0] ptr);
    logic [1:0] c;
    rr_pick = '0;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = NUM_LANES-1; k >= 0; k--) begin
      c = ptr + 2'(k);
      if (req[c]) begin
        rr_pick    = '0;
        rr_pick[c] = 1'b1;
      end
    end
  endfunction

  // Unpack the flat input bus into per-lane words (ch0 in the LSBs).
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_data[i] = bus.data_in[i*DW +: DW];
  end

  assign can_accept = !valid_q || bus.ready_in;
  assign grant      = rr_pick(bus.valid_in, ptr_q);

  // Accept nothing while reset is held: the flops cannot capture a beat then,
  // so a visible handshake would silently drop data.
  assign bus.ready_out = (can_accept && rst_n) ? grant : '0;
  assign xfer          = |bus.ready_out;

  // Encode the one-hot grant into a lane index.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (grant[i]) gidx = 2'(i);
  end

  // Next-state: load on transfer and rotate priority past the winner;
  // otherwise drain the register when the consumer takes it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = lane_data[gidx];
      ptr_d   = gidx + 2'd1;
    end else if (bus.ready_in) begin
      valid_d = 1'b0;
    end
  end

  // Output register and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
endmodule

// File: tb/tb_arbiter4.sv
// Bench for arbiter4: directed scenarios followed by random traffic, all
// checked against a transaction-level round-robin model.
module tb_arbiter4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arbiter4_if #(.DW(DW)) bus();
  arbiter4 #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Model state: what the output register should hold, and who is next in line.
  logic          ref_valid;
  logic [DW-1:0] ref_data;
  int            ref_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requesting channel in order ptr, ptr+1, ... mod 4; -1 if none.
  function automatic int ref_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic ref_reset();
    ref_valid = 1'b0;
    ref_data  = '0;
    ref_ptr   = 0;
  endtask

  // One cycle: check at the falling edge, advance the model, return just
  // after the rising edge so the caller can change inputs.
  task automatic step(input string tag);
    int         c;
    logic       acc;
    logic [3:0] exp_ro;
    @(negedge clk);
    acc    = !ref_valid || bus.ready_in;
    c      = ref_pick(bus.valid_in, ref_ptr);
    exp_ro = (acc && c >= 0) ? 4'(1 << c) : 4'b0000;
    chk({tag, ".ready_out"}, 32'(bus.ready_out), 32'(exp_ro));
    chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(ref_valid));
    chk({tag, ".data_out"},  32'(bus.data_out),  32'(ref_data));
    if (exp_ro != 4'b0000) begin
      ref_data  = bus.data_in[c*DW +: DW];
      ref_valid = 1'b1;
      ref_ptr   = (c + 1) % 4;
    end else if (bus.ready_in) begin
      ref_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] s3_seq [6];

  initial begin
    s3_seq = '{8'h43, 8'h65, 8'h87, 8'h21, 8'h43, 8'h65};

    // Reset held with all channels requesting.
    rst_n        = 1'b0;
    bus.valid_in = 4'b1111;
    bus.data_in  = 32'h87654321;
    bus.ready_in = 1'b0;
    ref_reset();
    #12;
    chk("rst.valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst.data_out",  32'(bus.data_out),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stalled consumer: ch0 loads, then everything holds.
    step("s2.a");
    chk("s2.first", 32'(bus.data_out), 32'h21);
    step("s2.b");
    step("s2.c");
    chk("s2.hold", 32'(bus.data_out), 32'h21);

    // Consumer ready: full rotation.
    bus.ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("s3");
      chk("s3.seq", 32'(bus.data_out), 32'(s3_seq[i]));
    end

    // One cycle of backpressure mid-stream.
    bus.ready_in = 1'b0;
    step("s4.stall");
    bus.ready_in = 1'b1;
    for (int i = 0; i < 4; i++) step("s4.resume");

    // Sparse requesters, then idle.
    bus.valid_in = 4'b0101;
    for (int i = 0; i < 4; i++) step("s5.sparse");
    bus.valid_in = 4'b0000;
    for (int i = 0; i < 2; i++) step("s5.idle");

    // Single requester keeps winning.
    bus.valid_in = 4'b0100;
    for (int i = 0; i < 3; i++) step("single");

    // Async reset between edges while the register is full.
    bus.valid_in = 4'b1111;
    bus.ready_in = 1'b0;
    step("s6.load");
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6.async_valid", 32'(bus.valid_out), 32'd0);
    chk("s6.async_data",  32'(bus.data_out),  32'd0);
    ref_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("s6.after");
    chk("s6.first_ch0", 32'(bus.data_out), 32'h21);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      bus.valid_in = 4'($urandom);
      bus.data_in  = $urandom;
      bus.ready_in = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
